// File: rtl/wreg_loader.sv
// Sparse weight loader: clears every weight register, then streams (row, weight)
// beats onto a shared bus with one-hot write enables and pulses done_o at the end.
module wreg_loader #(
    parameter int F_WIDTH    = 8,
    parameter int NUM_ROWS   = 8,
    parameter int ROW_ADDR_W = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic                      s_valid_i,
    output logic                      s_ready_o,
    input  logic signed [F_WIDTH-1:0] s_weight_i,
    input  logic [ROW_ADDR_W-1:0]     s_row_i,
    input  logic                      s_last_i,
    output logic signed [F_WIDTH-1:0] f_weight_o,
    output logic [NUM_ROWS-1:0]       wreg_wr_en_o,
    output logic                      wreg_rst_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic [ROW_ADDR_W:0]       nnz_o,
    output logic [2:0]                state_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [ROW_ADDR_W:0] ROWS_C = (ROW_ADDR_W + 1)'(NUM_ROWS);

    state_t                state;
    logic [ROW_ADDR_W:0]   beat_cnt;
    logic [ROW_ADDR_W:0]   cnt_inc;
    logic [NUM_ROWS-1:0]   row_onehot;
    logic                  row_ok;
    logic                  accept;
    logic                  cap_hit;

    // Stream handshake: a beat transfers on a rising edge where s_valid_i and
    // s_ready_o are both high; s_ready_o depends on the state register only.
    assign s_ready_o = (state == LOAD);
    assign busy_o    = (state != IDLE);
    assign state_o   = state;

    assign accept  = s_valid_i && (state == LOAD);
    assign cnt_inc = beat_cnt + 1'b1;
    assign cap_hit = (cnt_inc == ROWS_C);

    // Out-of-range indices decode to no enable at all, which doubles as the range check.
    always_comb begin
        row_onehot = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            row_onehot[r] = ({1'b0, s_row_i} == (ROW_ADDR_W + 1)'(r));
        end
    end

    assign row_ok = |row_onehot;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            beat_cnt     <= '0;
            f_weight_o   <= '0;
            wreg_wr_en_o <= '0;
            wreg_rst_o   <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            nnz_o        <= '0;
        end else begin
            wreg_wr_en_o <= '0;
            wreg_rst_o   <= 1'b0;
            done_o       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state      <= CLEAR;
                        wreg_rst_o <= 1'b1;
                        err_o      <= 1'b0;
                        nnz_o      <= '0;
                        beat_cnt   <= '0;
                    end
                end
                CLEAR: state <= LOAD;
                LOAD: begin
                    if (accept) begin
                        beat_cnt <= cnt_inc;
                        if (row_ok) begin
                            f_weight_o   <= s_weight_i;
                            wreg_wr_en_o <= row_onehot;
                            nnz_o        <= nnz_o + 1'b1;
                        end
                        // Sticky: bad index, or buffer filled without a last marker.
                        err_o <= err_o | ~row_ok | (cap_hit & ~s_last_i);
                        if (s_last_i || cap_hit) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    state  <= DONE;
                    done_o <= 1'b1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wreg_loader.sv
// Directed bench for wreg_loader: scoreboard queues for bus writes and done pulses,
// plus a model of the downstream weight registers.
module tb_wreg_loader;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              s_valid;
    logic              s_ready;
    logic signed [7:0] s_weight;
    logic [3:0]        s_row;
    logic              s_last;
    logic signed [7:0] f_weight;
    logic [7:0]        wr_en;
    logic              wreg_rst;
    logic              busy;
    logic              done;
    logic              err;
    logic [4:0]        nnz;
    logic [2:0]        state;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_q[$];
    logic [5:0]  done_q[$];
    logic [7:0]  regs[8];

    wreg_loader #(.F_WIDTH(8), .NUM_ROWS(8), .ROW_ADDR_W(4)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .s_weight_i(s_weight),
        .s_row_i(s_row), .s_last_i(s_last),
        .f_weight_o(f_weight), .wreg_wr_en_o(wr_en), .wreg_rst_o(wreg_rst),
        .busy_o(busy), .done_o(done), .err_o(err), .nnz_o(nnz), .state_o(state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // downstream weight registers
    always @(posedge clk) begin
        if (wreg_rst) begin
            for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
        end else begin
            for (int i = 0; i < 8; i++) if (wr_en[i]) regs[i] <= f_weight;
        end
    end

    // scoreboard monitor
    always @(negedge clk) begin : monitor
        logic [15:0] e;
        logic [5:0]  d;
        if (!rst) begin
            if (wr_en != 8'h00) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL write_sb: unexpected wr_en=%02h bus=%02h", wr_en, f_weight);
                end else begin
                    e = exp_q.pop_front();
                    if ({wr_en, f_weight} !== e) begin
                        failures++;
                        $display("FAIL write_sb: got wr_en=%02h bus=%02h expected wr_en=%02h bus=%02h",
                                 wr_en, f_weight, e[15:8], e[7:0]);
                    end
                end
            end
            if (done) begin
                checks++;
                if (done_q.size() == 0) begin
                    failures++;
                    $display("FAIL done_sb: unexpected done err=%0d nnz=%0d", err, nnz);
                end else begin
                    d = done_q.pop_front();
                    if ({err, nnz} !== d) begin
                        failures++;
                        $display("FAIL done_sb: got err=%0d nnz=%0d expected err=%0d nnz=%0d",
                                 err, nnz, d[5], d[4:0]);
                    end
                end
            end
        end
    end

    // driver tasks
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [3:0] row, input logic [7:0] w, input logic last,
                             input logic push, output int waits);
        int n;
        logic [7:0] oh;
        n        = 0;
        s_valid  = 1'b1;
        s_row    = row;
        s_weight = w;
        s_last   = last;
        @(negedge clk);
        while (!s_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!s_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: s_ready=%0d expected 1", s_ready);
        end else if (push && row < 4'd8) begin
            oh = 8'h01 << row;
            exp_q.push_back({oh, w});
        end
        @(posedge clk);
        #1;
        waits = n;
    endtask

    task automatic check_regs(input string name, input logic [63:0] exp);
        for (int i = 0; i < 8; i++) begin
            chk(name, {24'b0, regs[i]}, {24'b0, exp[i*8 +: 8]});
        end
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_state"}, {29'b0, state}, 32'd0);
        chk({name, "_outs"}, {19'b0, s_ready, busy, wreg_rst, done, err, wr_en},
            32'd0);
        chk({name, "_bus_nnz"}, {19'b0, nnz, f_weight}, 32'd0);
    endtask

    initial begin
        int w;
        int stalls;
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_weight = '0; s_row = '0; s_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_held");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("reset_released");

        // Test 1: two sparse beats
        done_q.push_back({1'b0, 5'd2});
        do_start();
        chk("t1_clear", {28'b0, state[1:0], wreg_rst, busy}, {28'b0, 2'd1, 1'b1, 1'b1});
        chk("t1_clear_ready", {31'b0, s_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("t1_load", {29'b0, state}, 32'd2);
        chk("t1_load_ready_rst", {30'b0, s_ready, wreg_rst}, {30'b0, 1'b1, 1'b0});
        send_beat(4'd2, 8'd5, 1'b0, 1'b1, w);
        chk("t1_first_wr", {16'b0, wr_en, f_weight}, 32'h0405);
        send_beat(4'd6, 8'hFD, 1'b1, 1'b1, w);
        s_valid = 1'b0;
        chk("t1_drain", {29'b0, state}, 32'd3);
        chk("t1_drain_wr", {15'b0, s_ready, wr_en, f_weight}, 32'h40FD);
        chk("t1_drain_nnz", {27'b0, nnz}, 32'd2);
        @(posedge clk);
        #1;
        chk("t1_done", {20'b0, state, done, wr_en}, {20'b0, 3'd4, 1'b1, 8'h00});
        @(posedge clk);
        #1;
        chk("t1_idle", {20'b0, state, busy, done, err, nnz}, {20'b0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd2});
        chk("t1_bus_hold", {24'b0, f_weight}, 32'h00FD);
        check_regs("t1_regs", 64'h00FD_0000_0005_0000);

        // Test 2: all rows back-to-back
        done_q.push_back({1'b0, 5'd8});
        stalls = 0;
        do_start();
        for (int i = 0; i < 8; i++) begin
            send_beat(4'(i), 8'(i + 1), (i == 7), 1'b1, w);
            if (i > 0) stalls += w;
        end
        chk("t2_no_stall", stalls, 0);
        chk("t2_drain_ready", {28'b0, state, s_ready}, {28'b0, 3'd3, 1'b0});
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        chk("t2_done", {31'b0, done}, 32'd1);
        @(posedge clk);
        #1;
        chk("t2_nnz", {27'b0, nnz}, 32'd8);
        check_regs("t2_regs", 64'h0807_0605_0403_0201);

        // Test 3: out-of-range row between valid beats
        done_q.push_back({1'b1, 5'd2});
        do_start();
        send_beat(4'd0, 8'd10, 1'b0, 1'b1, w);
        send_beat(4'd9, 8'd20, 1'b0, 1'b1, w);
        chk("t3_bad_row", {22'b0, err, nnz, wr_en}, {22'b0, 1'b1, 5'd1, 8'h00});
        send_beat(4'd3, 8'd30, 1'b1, 1'b1, w);
        s_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("t3_err_sticky", {26'b0, busy, err, nnz[3:0]}, {26'b0, 1'b0, 1'b1, 4'd2});
        check_regs("t3_regs", 64'h0000_0000_1E00_000A);

        // Test 4: NUM_ROWS beats without last
        done_q.push_back({1'b1, 5'd8});
        do_start();
        chk("t4_err_cleared", {26'b0, err, nnz}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            send_beat(4'(i), 8'(8'hF0 + i), 1'b0, 1'b1, w);
        end
        s_valid = 1'b0;
        chk("t4_drain", {28'b0, state, err}, {28'b0, 3'd3, 1'b1});
        @(posedge clk);
        #1;
        chk("t4_done", {31'b0, done}, 32'd1);
        @(posedge clk);
        #1;
        check_regs("t4_regs", 64'hF7F6_F5F4_F3F2_F1F0);

        // Test 5: duplicate row, start pulsed during LOAD
        done_q.push_back({1'b0, 5'd2});
        do_start();
        send_beat(4'd1, 8'd7, 1'b0, 1'b1, w);
        start = 1'b1;
        send_beat(4'd1, 8'hFF, 1'b1, 1'b1, w);
        start = 1'b0;
        s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t5_no_restart", {28'b0, state, busy}, 32'd0);
        check_regs("t5_regs", 64'h0000_0000_0000_FF00);

        // Test 6: asynchronous reset mid-LOAD, then a clean load
        do_start();
        send_beat(4'd4, 8'd9, 1'b0, 1'b0, w);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("t6_async_rst");
        s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        done_q.push_back({1'b0, 5'd2});
        do_start();
        send_beat(4'd5, 8'h33, 1'b0, 1'b1, w);
        send_beat(4'd4, 8'h44, 1'b1, 1'b1, w);
        s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_idle", {26'b0, state, err, nnz[1:0]}, {26'b0, 3'd0, 1'b0, 2'd2});
        check_regs("t6_regs", 64'h0000_3344_0000_0000);

        chk("write_queue_empty", exp_q.size(), 0);
        chk("done_queue_empty", done_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
